// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: state encodings and shared constants for the hazard controller
package pipe_hazard_ctrl_pkg;
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;
   localparam logic [4:0] REG_X0 = 5'd0;
   localparam int CNT_W = 16;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch redirect and halt-drain control
// PIPE_PERF_CNT_EN enables the stall/flush counters; otherwise they read 0.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int PC_SIZE      = 10,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [4:0]         id_rs1,
   input  logic [4:0]         id_rs2,
   input  logic               ex_valid,
   input  logic [4:0]         ex_rd,
   input  logic               ex_mem_read,
   input  logic               ex_branch,
   input  logic               ex_zero,
   input  logic [PC_SIZE-1:0] ex_pc_jump,
   input  logic               halt_req,
   output logic               pc_write,
   output logic               if_id_write,
   output logic               id_ex_bubble,
   output logic               if_id_flush,
   output logic               pc_sel,
   output logic [PC_SIZE-1:0] pc_target,
   output logic [1:0]         state,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   state_t st, nxt;
   logic [3:0] dcnt, dcnt_nxt;
   logic load_use, taken, hold, redirect, stall, run_taken;
   assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != REG_X0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   assign taken = ex_valid & ex_branch & ex_zero;
   assign hold = (st == DRAIN) | (st == HALT);
   assign run_taken = taken & (st == RUN);
   // FLUSH ignores the branch still sitting in EXE; DRAIN/HALT still honour it
   assign redirect = taken & (st != FLUSH);
   assign stall = load_use & (((st == RUN) & ~taken) | (st == FLUSH));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st   <= RUN;
         dcnt <= '0;
      end else begin
         st   <= nxt;
         dcnt <= dcnt_nxt;
      end
   always_comb begin
      nxt      = st;
      dcnt_nxt = dcnt;
      case (st)
         RUN:
            if (taken) nxt = FLUSH;
            else if (!load_use && halt_req) begin
               nxt      = DRAIN;
               dcnt_nxt = DRAIN_LOAD;
            end
         FLUSH:
            if (halt_req) begin
               nxt      = DRAIN;
               dcnt_nxt = DRAIN_LOAD;
            end else nxt = RUN;
         DRAIN:
            if (dcnt == '0) nxt = HALT;
            else dcnt_nxt = dcnt - 1'b1;
         HALT:
            if (!halt_req) nxt = RUN;
         default: nxt = RUN;
      endcase
   end
   always_comb begin
      pc_write     = ~(hold | stall);
      if_id_write  = ~(hold | stall);
      id_ex_bubble = hold | stall | run_taken;
      if_id_flush  = run_taken;
      pc_sel       = redirect;
      pc_target    = redirect ? ex_pc_jump : '0;
   end
   assign state = st;
`ifdef PIPE_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall),    .cnt(stall_cnt));
   sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(redirect), .cnt(flush_cnt));
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter PC_SIZE, default 10, giving the PC/branch-target width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, giving the bubble cycles injected before HALT (legal range 1..15).
REQ-003 SHALL have ports clk (in, 1, single clock) and rst_n (in, 1, asynchronous active-low reset), in that order.
REQ-004 SHALL have ports id_valid (in, 1, ID holds a real instruction), id_rs1 (in, 5), id_rs2 (in, 5).
REQ-005 SHALL have ports ex_valid (in, 1), ex_rd (in, 5), ex_mem_read (in, 1), ex_branch (in, 1), ex_zero (in, 1), ex_pc_jump (in, PC_SIZE; EXE branch target).
REQ-006 SHALL have port halt_req (in, 1, level request to drain and hold the pipeline).
REQ-007 SHALL have ports pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_sel (out, 1 each) and pc_target (out, PC_SIZE).
REQ-008 SHALL have ports state (out, 2, current FSM state), stall_cnt (out, 16) and flush_cnt (out, 16).

Function
REQ-009 SHALL implement FSM states RUN=0, FLUSH=1, DRAIN=2, HALT=3.
REQ-010 Definitions: load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2); taken = ex_valid & ex_branch & ex_zero.
REQ-011 All control outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-012 Default outputs: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pc_sel=0, pc_target=0.
REQ-013 RUN, taken: pc_sel=1, pc_target=ex_pc_jump, if_id_flush=1, id_ex_bubble=1; next state FLUSH.
REQ-014 RUN, load_use & !taken: pc_write=0, if_id_write=0, id_ex_bubble=1; state stays RUN; this repeats for each cycle the hazard persists.
REQ-015 Priority SHALL be taken > load_use > halt_req.
REQ-016 FLUSH lasts exactly one cycle; ex_branch is ignored there; load_use is applied as in RUN; next state is DRAIN if halt_req, else RUN.
REQ-017 RUN, halt_req & !taken: enter DRAIN; the drain counter loads DRAIN_CYCLES-1.
REQ-018 DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1.
REQ-019 DRAIN: the counter decrements each cycle; at 0 the next state is HALT.
REQ-020 DRAIN SHALL complete even if halt_req falls.
REQ-021 DRAIN, taken: pc_sel=1 and pc_target=ex_pc_jump; pc_sel=1 SHALL load the PC regardless of pc_write; draining continues.
REQ-022 HALT: outputs as DRAIN; when halt_req=0 the next state is RUN.
REQ-023 Total DRAIN+HALT residency SHALL be at least DRAIN_CYCLES+1 cycles.
REQ-024 stall_cnt increments on each load_use stall cycle; flush_cnt increments on each taken cycle; both saturate at 16'hFFFF.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0; outputs then take the REQ-012 defaults.
REQ-026 Reset mid-DRAIN/HALT/FLUSH SHALL abort the sequence.
REQ-027 The first edge after release SHALL evaluate in RUN.

Configuration
REQ-028 Macro PIPE_PERF_CNT_EN defined: stall_cnt/flush_cnt operate per REQ-024.
REQ-029 Macro PIPE_PERF_CNT_EN undefined: counter logic is absent, and stall_cnt and flush_cnt are tied to 0; all other behaviour is identical.

Structure
REQ-030 A shared package/include SHALL hold the state encodings (RUN/FLUSH/DRAIN/HALT), the register-x0 index constant and the counter width constant (16).
REQ-031 The hazard and redirect decode SHALL live in pipe_hazard_ctrl.
REQ-032 The saturating counter SHALL be one sub-module, sat_counter (parameter W), instantiated twice under PIPE_PERF_CNT_EN.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_valid=1, held one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cnt=1.
REQ-034 x0 case: as REQ-033 with ex_rd=0 -> no stall; all outputs default.
REQ-035 Taken branch: ex_branch=1, ex_zero=1, ex_pc_jump=10'h3C -> pc_sel=1, pc_target=10'h3C, if_id_flush=1; state=FLUSH next cycle, then RUN; flush_cnt=1.
REQ-036 Simultaneous taken and load_use -> redirect outputs only, pc_write=1, stall_cnt unchanged.
REQ-037 halt_req pulsed 1 cycle, DRAIN_CYCLES=3 -> 3 DRAIN cycles, 1 HALT cycle, then RUN.
REQ-038 halt_req held high -> remains in HALT; rst_n=0 during the second DRAIN cycle -> immediately state=RUN and counters=0.
REQ-039 Saturation (PIPE_PERF_CNT_EN defined): 70000 consecutive load-use cycles -> stall_cnt=16'hFFFF.
REQ-040 Saturation (PIPE_PERF_CNT_EN undefined): 70000 consecutive load-use cycles -> stall_cnt=0.
